// File: rtl/gat_pkg.sv
// Shared definitions for the GAT WH-row datapath: default geometry of a
// packed WH row and the state encoding of the BRAM writer.
package gat_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int WH_ROW_SIZE    = 16;
    localparam int NUM_OF_NODES   = 168;
    localparam int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES);
    localparam int WH_BRAM_WIDTH  = DATA_WIDTH * WH_ROW_SIZE + NUM_NODE_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } wh_state_e;

endpackage

// File: rtl/wh_elem_sat.sv
// Reduces a raw double-width product element to one stored element.
// Build option: define WH_SAT_EN to clamp values above the element maximum;
// without it the element is truncated to its low DATA_WIDTH bits.
module wh_elem_sat #(
    parameter int DATA_WIDTH = gat_pkg::DATA_WIDTH
) (
    input  logic [2*DATA_WIDTH-1:0] elem_i,
    output logic [DATA_WIDTH-1:0]   elem_o
);

`ifdef WH_SAT_EN
    localparam logic [2*DATA_WIDTH-1:0] MAX_VALUE = {{DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b1}}};

    // Clamp anything that does not fit in one element to all-ones.
    always_comb begin
        elem_o = (elem_i > MAX_VALUE) ? MAX_VALUE[DATA_WIDTH-1:0] : elem_i[DATA_WIDTH-1:0];
    end
`else
    logic unused_hi;
    assign unused_hi = ^elem_i[2*DATA_WIDTH-1:DATA_WIDTH];

    // Plain truncation: the upper half of the product is dropped.
    always_comb begin
        elem_o = elem_i[DATA_WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/wh_bram_writer.sv
// Packs a stream of WH elements into BRAM rows, one row per graph node.
// A sub-graph header gives the node count; each row carries WH_ROW_SIZE
// elements (element 0 in the MSBs), the node count, and a source-node flag
// in bit 0 set only on the first row of the sub-graph. The write address
// keeps running across sub-graphs and wraps at WH_BRAM_DEPTH.
// Element reduction is selected by the WH_SAT_EN macro (see wh_elem_sat).
module wh_bram_writer #(
    parameter int DATA_WIDTH      = gat_pkg::DATA_WIDTH,
    parameter int WH_ROW_SIZE     = gat_pkg::WH_ROW_SIZE,
    parameter int NUM_OF_NODES    = gat_pkg::NUM_OF_NODES,
    parameter int BRAM_ADDR_WIDTH = 32,
    parameter int WH_BRAM_DEPTH   = 256,
    localparam int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
    localparam int WH_BRAM_WIDTH  = DATA_WIDTH * WH_ROW_SIZE + NUM_NODE_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       subgraph_valid_i,
    input  logic [NUM_NODE_WIDTH-1:0]  num_of_nodes_i,
    output logic                       subgraph_ready_o,
    input  logic                       elem_valid_i,
    input  logic [2*DATA_WIDTH-1:0]    elem_i,
    output logic                       elem_ready_o,
    output logic                       WH_BRAM_ena,
    output logic                       WH_BRAM_wea,
    output logic [BRAM_ADDR_WIDTH-1:0] WH_BRAM_addra,
    output logic [WH_BRAM_WIDTH-1:0]   WH_BRAM_din,
    output logic                       wh_ready_o
);

    import gat_pkg::*;

    localparam int ELEM_CNT_W = (WH_ROW_SIZE > 1) ? $clog2(WH_ROW_SIZE) : 1;
    localparam int ROW_BITS   = DATA_WIDTH * WH_ROW_SIZE;
    localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR  = BRAM_ADDR_WIDTH'(WH_BRAM_DEPTH - 1);
    localparam logic [ELEM_CNT_W-1:0]      LAST_ELEM  = ELEM_CNT_W'(WH_ROW_SIZE - 1);

    wh_state_e                  state_q, state_d;
    logic [ELEM_CNT_W-1:0]      elem_cnt_q;
    logic [NUM_NODE_WIDTH-1:0]  node_cnt_q;
    logic [NUM_NODE_WIDTH-1:0]  row_cnt_q;
    logic [ROW_BITS-1:0]        row_q;
    logic [ROW_BITS-1:0]        row_next;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q;
    logic [WH_BRAM_WIDTH-1:0]   din_q;
    logic [DATA_WIDTH-1:0]      elem_st;
    logic [NUM_NODE_WIDTH:0]    rows_done;
    logic                       hdr_fire;
    logic                       elem_fire;
    logic                       last_elem;
    logic                       more_rows;

    wh_elem_sat #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sat (
        .elem_i(elem_i),
        .elem_o(elem_st)
    );

    assign hdr_fire  = subgraph_valid_i && subgraph_ready_o && (num_of_nodes_i != '0);
    assign elem_fire = elem_valid_i && elem_ready_o;
    assign last_elem = (elem_cnt_q == LAST_ELEM);
    // Each new element shifts in at the LSB end, so element 0 ends in the MSBs.
    assign row_next  = {row_q[ROW_BITS-DATA_WIDTH-1:0], elem_st};
    assign rows_done = {1'b0, row_cnt_q} + (NUM_NODE_WIDTH+1)'(1);
    assign more_rows = rows_done < {1'b0, node_cnt_q};

    assign WH_BRAM_addra = addr_q;
    assign WH_BRAM_din   = din_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignment so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake/BRAM strobes decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned and a latch is never inferred.
        state_d          = state_q;
        subgraph_ready_o = 1'b0;
        elem_ready_o     = 1'b0;
        WH_BRAM_ena      = 1'b0;
        WH_BRAM_wea      = 1'b0;
        wh_ready_o       = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so all outputs read zero.
                subgraph_ready_o = !rst;
                if (hdr_fire) state_d = FILL;
            end
            FILL: begin
                elem_ready_o = 1'b1;
                if (elem_valid_i && last_elem) state_d = WRITE;
            end
            WRITE: begin
                WH_BRAM_ena = 1'b1;
                WH_BRAM_wea = 1'b1;
                state_d     = more_rows ? FILL : DONE;
            end
            DONE: begin
                wh_ready_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, packing shift register, output row and running address.
    always_ff @(posedge clk) begin
        // NOTE: the packing register is an ordinary flop vector, not a RAM,
        // so clearing it in reset costs nothing and removes stale partials.
        if (rst) begin
            elem_cnt_q <= '0;
            node_cnt_q <= '0;
            row_cnt_q  <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            if (hdr_fire) begin
                node_cnt_q <= num_of_nodes_i;
                row_cnt_q  <= '0;
                elem_cnt_q <= '0;
            end
            if (elem_fire) begin
                row_q <= row_next;
                if (last_elem) begin
                    elem_cnt_q <= '0;
                    din_q      <= {row_next, node_cnt_q, (row_cnt_q == '0)};
                end else begin
                    elem_cnt_q <= elem_cnt_q + ELEM_CNT_W'(1);
                end
            end
            if (state_q == WRITE) begin
                row_cnt_q <= row_cnt_q + NUM_NODE_WIDTH'(1);
                addr_q    <= (addr_q == LAST_ADDR) ? '0 : addr_q + BRAM_ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_wh_bram_writer.sv
// Self-checking bench for wh_bram_writer (BRAM depth reduced to 4 so the
// address wrap is reached quickly). Expected rows come from a reference
// model that builds each row word from the element list with plain arithmetic.
module tb_wh_bram_writer;

    localparam int DW    = 8;
    localparam int RS    = 16;
    localparam int NN    = 168;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int NW    = $clog2(NN);
    localparam int W     = DW * RS + NW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          subgraph_valid_i;
    logic [NW-1:0] num_of_nodes_i;
    logic          subgraph_ready_o;
    logic          elem_valid_i;
    logic [2*DW-1:0] elem_i;
    logic          elem_ready_o;
    logic          WH_BRAM_ena;
    logic          WH_BRAM_wea;
    logic [AW-1:0] WH_BRAM_addra;
    logic [W-1:0]  WH_BRAM_din;
    logic          wh_ready_o;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int pulse_cnt = 0;
    int pulse_cycle = -100;
    int model_addr = 0;

    logic [AW-1:0] got_addr[$];
    logic [W-1:0]  got_din[$];
    logic          got_eready[$];
    int            got_wcycle[$];
    logic [AW-1:0] exp_addr[$];
    logic [W-1:0]  exp_din[$];
    logic [AW-1:0] snap_addr[$];
    logic [W-1:0]  snap_din[$];
    int            vals[$];

    always #5 clk = ~clk;

    wh_bram_writer #(
        .DATA_WIDTH(DW),
        .WH_ROW_SIZE(RS),
        .NUM_OF_NODES(NN),
        .BRAM_ADDR_WIDTH(AW),
        .WH_BRAM_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .subgraph_valid_i(subgraph_valid_i),
        .num_of_nodes_i(num_of_nodes_i),
        .subgraph_ready_o(subgraph_ready_o),
        .elem_valid_i(elem_valid_i),
        .elem_i(elem_i),
        .elem_ready_o(elem_ready_o),
        .WH_BRAM_ena(WH_BRAM_ena),
        .WH_BRAM_wea(WH_BRAM_wea),
        .WH_BRAM_addra(WH_BRAM_addra),
        .WH_BRAM_din(WH_BRAM_din),
        .wh_ready_o(wh_ready_o)
    );

    always @(posedge clk) cycle++;

    // Record every BRAM write and every completion pulse.
    always @(negedge clk) begin
        if (WH_BRAM_ena === 1'b1 && WH_BRAM_wea === 1'b1) begin
            got_addr.push_back(WH_BRAM_addra);
            got_din.push_back(WH_BRAM_din);
            got_eready.push_back(elem_ready_o);
            got_wcycle.push_back(cycle);
        end
        if (wh_ready_o === 1'b1) begin
            pulse_cnt++;
            pulse_cycle = cycle;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_elem(input int v);
`ifdef WH_SAT_EN
        if (v > (1 << DW) - 1) return {DW{1'b1}};
`endif
        return DW'(v % (1 << DW));
    endfunction

    function automatic logic [W-1:0] ref_row(input int n, input bit first, input int base);
        logic [W-1:0] d;
        d = '0;
        for (int k = 0; k < RS; k++) d[W-1-k*DW -: DW] = ref_elem(vals[base+k]);
        d[NW:1] = NW'(n);
        d[0]    = first;
        return d;
    endfunction

    task automatic fill_random(input int count);
        vals.delete();
        for (int i = 0; i < count; i++)
            vals.push_back($urandom_range(0, 1) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 65535)));
    endtask

    task automatic send_header(input int n);
        int k;
        @(negedge clk);
        subgraph_valid_i = 1'b1;
        num_of_nodes_i   = NW'(n);
        k = 0;
        while (subgraph_ready_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        check("hdr_ready", subgraph_ready_o, 1);
        @(negedge clk);
        subgraph_valid_i = 1'b0;
    endtask

    task automatic send_elem(input int v, input int gap);
        int k;
        elem_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        elem_valid_i = 1'b1;
        elem_i       = (2*DW)'(v);
        k = 0;
        while (elem_ready_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        check("elem_accept", elem_ready_o, 1);
        @(negedge clk);
        elem_valid_i = 1'b0;
    endtask

    task automatic run_subgraph(input int n, input int gap);
        int p0;
        int k;
        int last_wc;
        for (int r = 0; r < n; r++) begin
            exp_addr.push_back(AW'(model_addr));
            exp_din.push_back(ref_row(n, r == 0, r * RS));
            model_addr = (model_addr + 1) % DEPTH;
        end
        p0 = pulse_cnt;
        send_header(n);
        for (int i = 0; i < n * RS; i++) send_elem(vals[i], gap);
        k = 0;
        while (pulse_cnt == p0 && k < 200) begin @(negedge clk); #1; k++; end
        repeat (3) begin @(negedge clk); #1; end
        check("pulse_count", pulse_cnt - p0, 1);
        check("write_count", got_din.size(), n);
        last_wc = (got_wcycle.size() > 0) ? got_wcycle[got_wcycle.size()-1] : -10;
        check("pulse_timing", pulse_cycle, last_wc + 1);
        snap_addr = got_addr;
        snap_din  = got_din;
        while (got_din.size() > 0 && exp_din.size() > 0) begin
            check("waddr", got_addr.pop_front(), exp_addr.pop_front());
            check("wdin", got_din.pop_front(), exp_din.pop_front());
            check("eready_in_write", got_eready.pop_front(), 0);
            void'(got_wcycle.pop_front());
        end
        got_addr.delete(); got_din.delete(); got_eready.delete(); got_wcycle.delete();
        exp_addr.delete(); exp_din.delete();
    endtask

    initial begin
        int p0;
        logic [DW-1:0] sat_exp;
        rst = 1'b1;
        subgraph_valid_i = 1'b0;
        num_of_nodes_i   = '0;
        elem_valid_i     = 1'b0;
        elem_i           = '0;

        // Reset state: every output low while reset is held.
        repeat (3) @(negedge clk);
        check("rst_sg_ready", subgraph_ready_o, 0);
        check("rst_elem_ready", elem_ready_o, 0);
        check("rst_ena", WH_BRAM_ena, 0);
        check("rst_wea", WH_BRAM_wea, 0);
        check("rst_addr", WH_BRAM_addra, 0);
        check("rst_din", WH_BRAM_din, 0);
        check("rst_wh_ready", wh_ready_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_sg_ready", subgraph_ready_o, 1);
        check("idle_elem_ready", elem_ready_o, 0);

        // Two nodes, elements 1..32.
        vals.delete();
        for (int i = 1; i <= 32; i++) vals.push_back(i);
        run_subgraph(2, 0);
        check("seq_addr0", snap_addr[0], 0);
        check("seq_flag0", snap_din[0][0], 1);
        check("seq_cnt0", snap_din[0][NW:1], 2);
        check("seq_e0", snap_din[0][W-1 -: DW], 1);
        check("seq_e15", snap_din[0][W-1-15*DW -: DW], 16);
        check("seq_addr1", snap_addr[1], 1);
        check("seq_flag1", snap_din[1][0], 0);
        check("seq_e31", snap_din[1][W-1-15*DW -: DW], 32);

        // Oversized first element: clamped or truncated depending on build.
        fill_random(RS);
        vals[0] = 'h0134;
        run_subgraph(1, 0);
`ifdef WH_SAT_EN
        sat_exp = 8'hFF;
`else
        sat_exp = 8'h34;
`endif
        check("sat_elem0", snap_din[0][W-1 -: DW], sat_exp);

        // Valid toggled every other cycle: one row, all values in order.
        fill_random(RS);
        run_subgraph(1, 1);
        check("stall_writes", snap_din.size(), 1);

        // Fresh address space: 3 nodes then 2 nodes wrap through depth 4.
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        model_addr = 0;
        fill_random(3 * RS);
        run_subgraph(3, 0);
        check("wrap_a0", snap_addr[0], 0);
        check("wrap_a2", snap_addr[2], 2);
        check("wrap_flag_first", snap_din[0][0], 1);
        fill_random(2 * RS);
        run_subgraph(2, 0);
        check("wrap_a3", snap_addr[0], 3);
        check("wrap_a4", snap_addr[1], 0);
        check("wrap_flag_second", snap_din[0][0], 1);
        check("wrap_flag_second_r1", snap_din[1][0], 0);

        // Zero-node header is swallowed.
        p0 = pulse_cnt;
        send_header(0);
        repeat (5) @(negedge clk);
        #1;
        check("zero_sg_ready", subgraph_ready_o, 1);
        check("zero_elem_ready", elem_ready_o, 0);
        check("zero_writes", got_din.size(), 0);
        check("zero_pulse", pulse_cnt - p0, 0);

        // Reset part way through a row, then a clean one-node sub-graph.
        p0 = pulse_cnt;
        fill_random(RS);
        send_header(1);
        for (int i = 0; i < 10; i++) send_elem(vals[i], 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_ena", WH_BRAM_ena, 0);
        check("mid_rst_addr", WH_BRAM_addra, 0);
        rst = 1'b0;
        model_addr = 0;
        repeat (4) @(negedge clk);
        #1;
        check("mid_rst_writes", got_din.size(), 0);
        check("mid_rst_pulse", pulse_cnt - p0, 0);
        fill_random(RS);
        run_subgraph(1, 0);
        check("post_rst_addr", snap_addr[0], 0);
        check("post_rst_flag", snap_din[0][0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
